// File: rtl/cle_sram_packer.sv
// cle_sram_packer: scans the 32x32 bit-per-byte image held in a 1024x8 SRAM
// and packs it into 128 bytes (8 pixels per byte, MSB first), writing each
// packed byte to an output memory port. This is the inverse of the CLE
// ROM-to-SRAM unpack stage.
// Optional build macro: CLE_PACK_NONZERO_EN -- any nonzero SRAM byte packs
// as a 1 (foreground mask of a labelled image) instead of using bit 0 only.
module cle_sram_packer #(
    parameter int SWIDTH = 10,
    parameter int DWIDTH = 8,
    parameter int OWIDTH = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DWIDTH-1:0] sram_q,
    output logic [SWIDTH-1:0] sram_a,
    output logic              sram_wen,
    output logic [OWIDTH-1:0] out_a,
    output logic [DWIDTH-1:0] out_d,
    output logic              out_we,
    output logic              busy,
    output logic              finish
);

    localparam int BIT_W = $clog2(DWIDTH);
    localparam logic [SWIDTH-1:0] LAST_A = '1;
    // DRAIN spans a fixed 10 cycles, so finish always rises 1034 cycles
    // after the first READ cycle; the last strobe lands inside that window.
    localparam logic [3:0] DRAIN_LAST = 4'd9;

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t            state;
    state_t            state_nxt;
    logic              launch;
    logic              rd_v;
    logic              pix;
    logic [DWIDTH-1:0] shreg;
    logic [SWIDTH-1:0] pix_cnt;
    logic [3:0]        drain_cnt;

    // Pixel value extracted from one SRAM byte.
    function automatic logic pack_bit(input logic [DWIDTH-1:0] q);
`ifdef CLE_PACK_NONZERO_EN
        return |q;
`else
        return q[0];
`endif
    endfunction

`ifndef CLE_PACK_NONZERO_EN
    logic unused_q_hi;
    assign unused_q_hi = ^sram_q[DWIDTH-1:1];
`endif

    assign pix      = pack_bit(sram_q);
    assign launch   = start && (state == IDLE || state == DONE);
    assign sram_wen = 1'b1;
    assign busy     = (state == READ) || (state == DRAIN);
    assign finish   = (state == DONE);

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; start is only honoured in IDLE and DONE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = READ;
            READ:    if (sram_a == LAST_A) state_nxt = DRAIN;
            DRAIN:   if (drain_cnt == DRAIN_LAST) state_nxt = DONE;
            DONE:    if (start) state_nxt = READ;
            default: state_nxt = IDLE;
        endcase
    end

    // Address generation, read-valid tracking, pixel shifting and byte writes.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sram_a    <= '0;
            rd_v      <= 1'b0;
            shreg     <= '0;
            pix_cnt   <= '0;
            drain_cnt <= '0;
            out_a     <= '0;
            out_d     <= '0;
            out_we    <= 1'b0;
        end else begin
            out_we <= 1'b0;
            rd_v   <= (state == READ);
            if (launch) begin
                sram_a    <= '0;
                shreg     <= '0;
                pix_cnt   <= '0;
                drain_cnt <= '0;
            end else begin
                // Address saturates at the last entry until the next launch.
                if (state == READ && sram_a != LAST_A) sram_a <= sram_a + 1'b1;
                if (state == DRAIN) drain_cnt <= drain_cnt + 4'd1;
                if (rd_v) begin
                    shreg   <= {shreg[DWIDTH-2:0], pix};
                    pix_cnt <= pix_cnt + 1'b1;
                    // Eighth pixel of a byte: emit the completed byte.
                    if (&pix_cnt[BIT_W-1:0]) begin
                        out_d  <= {shreg[DWIDTH-2:0], pix};
                        out_a  <= pix_cnt[SWIDTH-1:BIT_W];
                        out_we <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_cle_sram_packer.sv
// Testbench for cle_sram_packer: SRAM model, cycle-level reference model of
// the scan timeline and packed image, directed scenarios and literal checks.
module tb_cle_sram_packer;

    localparam int BIG = 1 << 30;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] sram_q;
    logic [9:0] sram_a;
    logic       sram_wen;
    logic [6:0] out_a;
    logic [7:0] out_d;
    logic       out_we;
    logic       busy;
    logic       finish;

    cle_sram_packer dut (
        .clk(clk), .reset(reset), .start(start), .sram_q(sram_q),
        .sram_a(sram_a), .sram_wen(sram_wen), .out_a(out_a), .out_d(out_d),
        .out_we(out_we), .busy(busy), .finish(finish)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [1024];
    always @(posedge clk) sram_q <= mem[sram_a];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    // model state
    int   r0 = BIG;
    int   kill_c = 0;
    bit   scan_valid = 0;
    bit   prev_fin = 0;
    int   prev_sa = 0;
    int   ea = 0;
    int   ed = 0;
    int   exp_pack [128];

    // captured DUT dump for literal checks
    logic [7:0] cap [128];
    logic [7:0] prev_cap [128];
    int   strobe_cnt = 0;
    int   first_we_c = -1;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic int pixel(input logic [7:0] v);
`ifdef CLE_PACK_NONZERO_EN
        return (v != 0) ? 1 : 0;
`else
        return (v % 2 == 1) ? 1 : 0;
`endif
    endfunction

    // Per-cycle compare against the timeline model.
    always @(negedge clk) begin
        int c, d, e_sa;
        bit e_busy, e_fin, e_we;
        if (cyc >= 1) begin
            c = cyc;
            e_we = 0;
            if (scan_valid && c >= r0 && c < kill_c) begin
                d = c - r0;
                e_busy = (d <= 1033);
                e_fin  = (d >= 1034);
                e_sa   = (d < 1023) ? d : 1023;
                e_we   = (d >= 9) && (d <= 1025) && ((d - 9) % 8 == 0);
                if (e_we) begin
                    ea = (d - 9) / 8;
                    ed = exp_pack[ea];
                end
            end else if (c >= kill_c) begin
                e_busy = 0; e_fin = 0; e_sa = 0;
                ea = 0; ed = 0;
            end else begin
                e_busy = 0; e_fin = prev_fin; e_sa = prev_sa;
            end
            chk("busy", int'(busy), int'(e_busy));
            chk("finish", int'(finish), int'(e_fin));
            chk("out_we", int'(out_we), int'(e_we));
            chk("sram_a", int'(sram_a), e_sa);
            chk("out_a", int'(out_a), ea);
            chk("out_d", int'(out_d), ed);
            chk("sram_wen", int'(sram_wen), 1);
            if (out_we === 1'b1) begin
                strobe_cnt++;
                cap[out_a] = out_d;
                if (first_we_c < 0) first_we_c = c;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_start();
        int v;
        if (cyc >= kill_c) begin
            prev_fin = 0; prev_sa = 0;
        end else if (scan_valid) begin
            prev_fin = 1; prev_sa = 1023;
        end else begin
            prev_fin = 0; prev_sa = 0;
        end
        for (int n = 0; n < 128; n++) begin
            v = 0;
            for (int b = 0; b < 8; b++) v = v * 2 + pixel(mem[8 * n + b]);
            exp_pack[n] = v;
            cap[n] = 8'hxx;
        end
        strobe_cnt = 0;
        first_we_c = -1;
        r0 = cyc + 1;
        kill_c = BIG;
        scan_valid = 1;
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic wait_done();
        while (cyc < r0 + 1036) step(1);
    endtask

    task automatic fill_zero();
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    endtask

    initial begin
        int diff;
        logic [7:0] exp4;
`ifdef CLE_PACK_NONZERO_EN
        exp4 = 8'h80;
`else
        exp4 = 8'h00;
`endif
        reset = 1'b0;
        start = 1'b0;
        fill_zero();
        step(4);
        reset = 1'b1;
        step(3);

        // all-zero image
        do_start();
        wait_done();
        chk("first_strobe_latency", first_we_c - r0, 9);
        chk("strobes_zero", strobe_cnt, 128);
        chk("zero_byte0", int'(cap[0]), 8'h00);
        chk("zero_byte127", int'(cap[127]), 8'h00);

        // corner pixels, restarted straight from DONE
        mem[0] = 8'h01;
        mem[1023] = 8'h01;
        do_start();
        wait_done();
        chk("corner_byte0", int'(cap[0]), 8'h80);
        chk("corner_byte127", int'(cap[127]), 8'h01);
        chk("corner_byte1", int'(cap[1]), 8'h00);

        // alternating 1,0,1,0...
        for (int i = 0; i < 1024; i++) mem[i] = (i % 2 == 0) ? 8'h01 : 8'h00;
        do_start();
        wait_done();
        chk("alt_byte5", int'(cap[5]), 8'hAA);
        chk("alt_byte127", int'(cap[127]), 8'hAA);
        chk("alt_strobes", strobe_cnt, 128);

        // ignored extra start, then reset mid-scan, then a fresh full dump
        do_start();
        while (cyc < r0 + 99) step(1);
        start = 1'b1;
        step(1);
        start = 1'b0;
        while (cyc < r0 + 499) step(1);
        reset = 1'b0;
        kill_c = cyc + 1;
        step(3);
        reset = 1'b1;
        step(20);
        chk("abort_strobes", strobe_cnt, 62);
        do_start();
        wait_done();
        chk("restart_strobes", strobe_cnt, 128);
        chk("restart_byte64", int'(cap[64]), 8'hAA);

        // bit0 vs nonzero extraction
        fill_zero();
        mem[8] = 8'h05;
        do_start();
        wait_done();
        chk("q05_byte1", int'(cap[1]), 8'h80);
        mem[8] = 8'h04;
        do_start();
        wait_done();
        chk("q04_byte1", int'(cap[1]), int'(exp4));

        // back-to-back identical dumps
        for (int n = 0; n < 128; n++) prev_cap[n] = cap[n];
        do_start();
        wait_done();
        diff = 0;
        for (int n = 0; n < 128; n++) if (cap[n] !== prev_cap[n]) diff++;
        chk("repeat_dump_diffs", diff, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
